// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side handshake bundle for the direct-mapped instruction cache.
// slave = the cache itself, master = the IF stage / memory controller side.
interface icache_dm_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic        if_inst_valid;
  logic [31:0] if_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_inst_valid;
  logic [31:0] mem_inst;

  modport slave (
    input  if_req, if_addr, if_flush, mem_inst_valid, mem_inst,
    output if_ready, if_inst_valid, if_inst, mem_req, mem_addr
  );

  modport master (
    output if_req, if_addr, if_flush, mem_inst_valid, mem_inst,
    input  if_ready, if_inst_valid, if_inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with single outstanding refill.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_dm #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic                  if_inst_valid_q, if_inst_valid_d;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit, fill_en, acc_hit, acc_miss;
  logic                  addr_lo_unused;

  assign req_idx  = bus.if_addr[INDEX_BITS+1:2];
  assign req_tag  = bus.if_addr[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign addr_lo_unused = ^bus.if_addr[1:0];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    mem_addr_d      = mem_addr_q;
    if_inst_d       = if_inst_q;
    if_inst_valid_d = 1'b0;
    fill_en         = 1'b0;
    acc_hit         = 1'b0;
    acc_miss        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req && !bus.if_flush) begin
          if (hit) begin
            acc_hit         = 1'b1;
            if_inst_valid_d = 1'b1;
            if_inst_d       = data_q[req_idx];
          end else begin
            acc_miss   = 1'b1;
            mem_addr_d = {bus.if_addr[31:2], 2'b00};
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        // A refill word that races a flush still installs the line; only the response is dropped.
        if (bus.mem_inst_valid) begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
          if (!bus.if_flush) begin
            if_inst_valid_d = 1'b1;
            if_inst_d       = bus.mem_inst;
          end
        end else if (bus.if_flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      mem_addr_q      <= '0;
      if_inst_q       <= '0;
      if_inst_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      mem_addr_q      <= mem_addr_d;
      if_inst_q       <= if_inst_d;
      if_inst_valid_q <= if_inst_valid_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_inst;
    end
  end

  assign bus.if_ready      = (state_q == IDLE);
  assign bus.mem_req       = (state_q == MISS) && !bus.mem_inst_valid;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.if_inst       = if_inst_q;
  assign bus.if_inst_valid = if_inst_valid_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + (acc_hit ? 32'd1 : 32'd0);
    miss_cnt_d = miss_cnt_q + (acc_miss ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a line-level behavioural model.
module tb_icache_dm;
  localparam int IB    = 7;
  localparam int LINES = 1 << IB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_dm_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache_dm #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
`else
  icache_dm #(.INDEX_BITS(IB)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Values sampled at the falling edge of the most recent cycle.
  logic        s_ready, s_mem_req, s_iv;
  logic [31:0] s_inst, s_mem_addr;

  // Model: which word address lives in each line, its data, and the outstanding refill (if any).
  logic [29:0] resident [int];
  logic [31:0] line_data [int];
  logic [31:0] pending [$];
  logic [31:0] m_addr, m_inst;
  logic        m_iv;
  int unsigned m_hits, m_misses;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        mv;
    logic [31:0] mi;
    logic        e_ready;
    logic        e_mem_req;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_mem_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic flush,
                       input logic mv, input logic [31:0] mi);
    bus.if_req         = req;
    bus.if_addr        = addr;
    bus.if_flush       = flush;
    bus.mem_inst_valid = mv;
    bus.mem_inst       = mi;
  endtask

  task automatic model_reset();
    resident.delete();
    line_data.delete();
    pending.delete();
    m_addr   = '0;
    m_inst   = '0;
    m_iv     = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_step();
    int          idx;
    logic [29:0] word;
    logic        nxt_iv;
    nxt_iv = 1'b0;
    if (pending.size() == 0) begin
      if (bus.if_req && !bus.if_flush) begin
        word = bus.if_addr[31:2];
        idx  = int'(word % LINES);
        if (resident.exists(idx) && resident[idx] == word) begin
          nxt_iv = 1'b1;
          m_inst = line_data[idx];
          m_hits++;
        end else begin
          m_addr = {word, 2'b00};
          pending.push_back(m_addr);
          m_misses++;
        end
      end
    end else if (bus.mem_inst_valid) begin
      word = pending[0][31:2];
      idx  = int'(word % LINES);
      resident[idx]  = word;
      line_data[idx] = bus.mem_inst;
      pending.delete();
      if (!bus.if_flush) begin
        nxt_iv = 1'b1;
        m_inst = bus.mem_inst;
      end
    end else if (bus.if_flush) begin
      pending.delete();
    end
    m_iv = nxt_iv;
  endtask

  // One clock: sample at negedge, compare against model, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    s_ready    = bus.if_ready;
    s_mem_req  = bus.mem_req;
    s_iv       = bus.if_inst_valid;
    s_inst     = bus.if_inst;
    s_mem_addr = bus.mem_addr;
    if (!rst) begin
      check("model.if_ready", 32'(s_ready), 32'(pending.size() == 0));
      check("model.mem_req", 32'(s_mem_req), 32'(pending.size() != 0 && !bus.mem_inst_valid));
      check("model.mem_addr", s_mem_addr, m_addr);
      check("model.if_inst_valid", 32'(s_iv), 32'(m_iv));
      check("model.if_inst", s_inst, m_inst);
`ifdef ICACHE_STATS_EN
      check("model.hit_cnt", hit_cnt, m_hits);
      check("model.miss_cnt", miss_cnt, m_misses);
`endif
    end
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic cyc(input logic req, input logic [31:0] addr, input logic flush,
                     input logic mv, input logic [31:0] mi);
    drive(req, addr, flush, mv, mi);
    cycle();
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic in_miss;
    // Reset, cold miss on 0x0 with 5 wait cycles, then a hit on the same address.
    vecs[0] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h93, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h93, 32'h0};
    vecs[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h93, 32'h0};
    vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h93, 32'h0};

    model_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].req, vecs[i].addr, vecs[i].flush, vecs[i].mv, vecs[i].mi);
      check($sformatf("vec%0d.if_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d.mem_req", i), 32'(s_mem_req), 32'(vecs[i].e_mem_req));
      check($sformatf("vec%0d.if_inst_valid", i), 32'(s_iv), 32'(vecs[i].e_iv));
      check($sformatf("vec%0d.if_inst", i), s_inst, vecs[i].e_inst);
      check($sformatf("vec%0d.mem_addr", i), s_mem_addr, vecs[i].e_mem_addr);
    end
`ifdef ICACHE_STATS_EN
    check("stats.hit_cnt_after_hit", hit_cnt, 32'd1);
    check("stats.miss_cnt_after_hit", miss_cnt, 32'd1);
`endif

    // Conflict eviction: 0x004 and 0x204 share index 1.
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    idle();
    check("conflict.first_miss_addr", s_mem_addr, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0004);
    idle();
    check("conflict.first_fill_data", s_inst, 32'h1111_0004);
    cyc(1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
    idle();
    check("conflict.second_miss_req", 32'(s_mem_req), 32'd1);
    check("conflict.second_miss_addr", s_mem_addr, 32'h204);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0204);
    idle();
    check("conflict.second_fill_data", s_inst, 32'h2222_0204);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    idle();
    check("conflict.evicted_miss", 32'(s_mem_req), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0004);
    idle();

    // Flush during a refill wait abandons it without filling.
    cyc(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("flush_miss.req_in_flush_cycle", 32'(s_mem_req), 32'd1);
    idle();
    check("flush_miss.req_dropped", 32'(s_mem_req), 32'd0);
    check("flush_miss.ready_back", 32'(s_ready), 32'd1);
    check("flush_miss.no_pulse", 32'(s_iv), 32'd0);
    cyc(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
    idle();
    check("flush_miss.re_miss", 32'(s_mem_req), 32'd1);
    check("flush_miss.re_miss_addr", s_mem_addr, 32'h1000);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000);
    idle();

    // Flush coinciding with refill data: line filled, response suppressed.
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    idle();
    check("flush_fill.no_pulse", 32'(s_iv), 32'd0);
    check("flush_fill.ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    idle();
    check("flush_fill.rehit_pulse", 32'(s_iv), 32'd1);
    check("flush_fill.rehit_data", s_inst, 32'hDEAD_BEEF);
    check("flush_fill.rehit_no_mem_req", 32'(s_mem_req), 32'd0);

    // Flush in IDLE drops the new request but still delivers the previous hit.
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
    check("idle_flush.prior_hit_delivered", 32'(s_iv), 32'd1);
    idle();
    check("idle_flush.request_dropped", 32'(s_iv), 32'd0);

    // Stray refill pulse in IDLE is ignored.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    idle();
    check("idle_mem_valid.no_pulse", 32'(s_iv), 32'd0);
    check("idle_mem_valid.inst_held", s_inst, 32'hDEAD_BEEF);

    // Reset mid-MISS with a refill word in the reset cycle: no fill, counters cleared.
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    idle();
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    rst = 1'b0;
    idle();
    check("rst_miss.mem_req_low", 32'(s_mem_req), 32'd0);
    check("rst_miss.ready", 32'(s_ready), 32'd1);
    check("rst_miss.no_pulse", 32'(s_iv), 32'd0);
    check("rst_miss.inst_cleared", s_inst, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_miss.hit_cnt", hit_cnt, 32'd0);
    check("rst_miss.miss_cnt", miss_cnt, 32'd0);
`endif
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    idle();
    check("rst_miss.not_filled", 32'(s_mem_req), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
    idle();

    // Randomized traffic over a small address pool to mix hits, conflicts and flushes.
    for (int n = 0; n < 3000; n++) begin
      in_miss = (pending.size() != 0);
      drive($urandom_range(0, 3) != 0,
            (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
            $urandom_range(0, 11) == 0,
            in_miss ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0),
            $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 7, log2 of line count (128 one-word lines).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port if_req  input  1  fetch request from IF stage.
REQ-005 The block SHALL have port if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 The block SHALL have port if_flush  input  1  abort outstanding fetch (branch redirect).
REQ-007 The block SHALL have port if_ready  output  1  fetch accepted this cycle when high.
REQ-008 The block SHALL have port if_inst_valid  output  1  one-cycle pulse, if_inst valid.
REQ-009 The block SHALL have port if_inst  output  32  fetched instruction word.
REQ-010 The block SHALL have port mem_req  output  1  refill request to memory controller (icache_needed).
REQ-011 The block SHALL have port mem_addr  output  32  word-aligned refill address (icache_addr).
REQ-012 The block SHALL have port mem_inst_valid  input  1  refill word valid pulse from controller.
REQ-013 The block SHALL have port mem_inst  input  32  refill word, little-endian assembled.

Function
REQ-014 Address split SHALL be: index = if_addr[INDEX_BITS+1:2], tag = if_addr[31:INDEX_BITS+2].
REQ-015 Storage SHALL be per-line valid bit, tag, 32-bit data; direct-mapped, no write path from data stores.
REQ-016 FSM states SHALL be IDLE, MISS; if_ready = (state == IDLE), combinational.
REQ-017 IDLE, if_req, hit (valid && tag match): next cycle if_inst_valid=1, if_inst=line data; stay IDLE (1-cycle hit latency, back-to-back hits every cycle).
REQ-018 IDLE, if_req, miss: latch {if_addr[31:2],2'b00} into mem_addr; next state MISS; no if_inst_valid.
REQ-019 mem_req SHALL be combinational: 1 in MISS while mem_inst_valid=0, else 0; mem_addr held stable throughout MISS.
REQ-020 MISS, mem_inst_valid=1: write mem_inst to line, set valid, store tag; next cycle if_inst_valid=1, if_inst=mem_inst; state IDLE.
REQ-021 Controller busy with data access SHALL only stretch MISS; no timeout.
REQ-022 if_flush in IDLE: any same-cycle if_req SHALL be dropped, no output pulse; pending hit response of previous cycle still delivered.
REQ-023 if_flush in MISS without mem_inst_valid: state IDLE next cycle, mem_req low next cycle, no fill, no if_inst_valid.
REQ-024 if_flush and mem_inst_valid same cycle: line SHALL be filled, if_inst_valid SHALL NOT pulse; state IDLE.
REQ-025 mem_inst_valid in IDLE SHALL be ignored.
REQ-026 if_inst SHALL hold its last value when if_inst_valid=0.

Reset
REQ-027 rst SHALL clear all valid bits, state to IDLE, if_inst_valid=0, if_inst=0, mem_addr=0 (hence mem_req=0, if_ready=1 after reset).
REQ-028 rst mid-MISS SHALL abandon the refill; a mem_inst_valid arriving in the reset cycle SHALL not fill.
REQ-029 Tag/data arrays need not be reset.

Configuration
REQ-030 Macro ICACHE_STATS_EN defined: ports hit_cnt output 32 and miss_cnt output 32 SHALL exist, reset to 0, increment once per accepted hit / accepted miss (REQ-017/018), wrap at 2^32-1 to 0; flushed requests not counted.
REQ-031 ICACHE_STATS_EN undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, if_req addr 0x00000000 -> mem_req=1, mem_addr=0x00000000; mem_inst_valid with 0x00000093 after 5 cycles -> next cycle if_inst_valid=1, if_inst=0x00000093.
REQ-033 Then if_req 0x00000000 again -> mem_req stays 0, if_inst_valid next cycle with 0x00000093 (hit).
REQ-034 Fill 0x00000004, then if_req 0x00000204 (same index, INDEX_BITS=7) -> miss, mem_addr=0x00000204; refill evicts; re-request 0x00000004 -> miss.
REQ-035 Miss on 0x00001000, if_flush after 2 cycles -> mem_req low next cycle, no if_inst_valid; re-request 0x00001000 -> miss again.
REQ-036 Miss on 0x00000010, if_flush coincident with mem_inst_valid (0xDEADBEEF) -> no pulse; re-request -> hit with 0xDEADBEEF.
REQ-037 ICACHE_STATS_EN: sequence of REQ-032..033 -> hit_cnt=1, miss_cnt=1; rst mid-MISS -> both 0, mem_req=0.
